// File: rtl/lmac_rx_unloader.sv
// lmac_rx_unloader: drains the LMAC RX FIFO into a framed valid/ready word stream with SOP/EOP repair.
// Define RX_UNLOADER_STATS_EN to add the rx_pkt_cnt/rx_err_cnt statistics counters and stats_clr.
module lmac_rx_unloader #(
    parameter int DATA_W        = 64,
    parameter int MAX_PKT_WORDS = 1200,
    parameter int CNT_W         = 32
) (
    input  logic              clk,
    input  logic              reset_,
    input  logic [DATA_W-1:0] rx_mac_data,
    input  logic [7:0]        rx_mac_ctrl,
    input  logic              rx_mac_empty,
    output logic              rx_mac_rd,
    output logic [DATA_W-1:0] m_data,
    output logic              m_sop,
    output logic              m_eop,
    output logic              m_valid,
    input  logic              m_ready,
    output logic              frm_err,
    output logic [1:0]        fsm_state
`ifdef RX_UNLOADER_STATS_EN
    ,
    output logic [CNT_W-1:0]  rx_pkt_cnt,
    output logic [CNT_W-1:0]  rx_err_cnt,
    input  logic              stats_clr
`endif
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        IN_PKT  = 2'd1,
        DISCARD = 2'd2
    } state_t;

    localparam logic [13:0] LAST_CNT = 14'(MAX_PKT_WORDS - 1);

    state_t            state, state_nxt;
    logic [13:0]       wcnt, wcnt_nxt;
    logic              inflight;
    logic [1:0]        skid_cnt;
    logic [DATA_W+1:0] skid0, skid1;   // {sop, eop, data}; skid0 is the head
    logic [DATA_W+1:0] skid_in;
    logic              push, push_sop, push_eop, pop;
    logic              word_s, word_e;
    logic [2:0]        used;
    logic              unused_ctrl;

    assign word_s      = rx_mac_ctrl[0];
    assign word_e      = rx_mac_ctrl[1];
    assign unused_ctrl = ^rx_mac_ctrl[7:2];
    assign fsm_state   = state;

    // Output handshake: a beat transfers on a cycle where m_valid & m_ready; while m_valid is high
    // and m_ready is low the head word (data/sop/eop) is held unchanged.
    assign m_valid = (skid_cnt != 2'd0);
    assign m_data  = skid0[DATA_W-1:0];
    assign m_sop   = m_valid & skid0[DATA_W+1];
    assign m_eop   = m_valid & skid0[DATA_W];
    assign pop     = m_valid & m_ready;

    // A word popped this cycle frees its slot in time for a read issued now, giving 1 word/cycle.
    assign used      = {1'b0, skid_cnt} + {2'b0, inflight} - {2'b0, pop};
    assign rx_mac_rd = reset_ & ~rx_mac_empty & (used < 3'd2);

    always_ff @(posedge clk or negedge reset_) begin
        if (!reset_) begin
            state    <= IDLE;
            wcnt     <= '0;
            inflight <= 1'b0;
        end else begin
            state    <= state_nxt;
            wcnt     <= wcnt_nxt;
            inflight <= rx_mac_rd;
        end
    end

    always_comb begin
        state_nxt = state;
        wcnt_nxt  = wcnt;
        push      = 1'b0;
        push_sop  = 1'b0;
        push_eop  = 1'b0;
        frm_err   = 1'b0;
        if (inflight) begin
            case (state)
                IN_PKT: begin
                    if (word_s) begin
                        // New start inside a packet: the old one stays open downstream.
                        push     = 1'b1;
                        push_sop = 1'b1;
                        frm_err  = 1'b1;
                        if (word_e) begin
                            push_eop  = 1'b1;
                            state_nxt = IDLE;
                        end else begin
                            wcnt_nxt = 14'd1;
                        end
                    end else if (word_e) begin
                        push      = 1'b1;
                        push_eop  = 1'b1;
                        state_nxt = IDLE;
                    end else if (wcnt == LAST_CNT) begin
                        push      = 1'b1;
                        push_eop  = 1'b1;
                        frm_err   = 1'b1;
                        state_nxt = DISCARD;
                    end else begin
                        push = 1'b1;
                        if (wcnt != 14'h3fff) wcnt_nxt = wcnt + 14'd1;
                    end
                end
                DISCARD: begin
                    if (word_s && !word_e) begin
                        push      = 1'b1;
                        push_sop  = 1'b1;
                        wcnt_nxt  = 14'd1;
                        state_nxt = IN_PKT;
                    end else if (word_e) begin
                        state_nxt = IDLE;
                    end
                end
                default: begin
                    if (word_s) begin
                        push     = 1'b1;
                        push_sop = 1'b1;
                        if (word_e) begin
                            push_eop = 1'b1;
                        end else begin
                            wcnt_nxt  = 14'd1;
                            state_nxt = IN_PKT;
                        end
                    end else begin
                        frm_err   = 1'b1;
                        state_nxt = word_e ? IDLE : DISCARD;
                    end
                end
            endcase
        end
    end

    assign skid_in = {push_sop, push_eop, rx_mac_data};

    always_ff @(posedge clk or negedge reset_) begin
        if (!reset_) begin
            skid_cnt <= 2'd0;
            skid0    <= '0;
            skid1    <= '0;
        end else begin
            case ({push, pop})
                2'b10: begin
                    if (skid_cnt == 2'd0) skid0 <= skid_in;
                    else                  skid1 <= skid_in;
                    skid_cnt <= skid_cnt + 2'd1;
                end
                2'b01: begin
                    skid0    <= skid1;
                    skid_cnt <= skid_cnt - 2'd1;
                end
                2'b11: begin
                    if (skid_cnt == 2'd1) begin
                        skid0 <= skid_in;
                    end else begin
                        skid0 <= skid1;
                        skid1 <= skid_in;
                    end
                end
                default: begin
                end
            endcase
        end
    end

`ifdef RX_UNLOADER_STATS_EN
    always_ff @(posedge clk or negedge reset_) begin
        if (!reset_) begin
            rx_pkt_cnt <= '0;
            rx_err_cnt <= '0;
        end else if (stats_clr) begin
            rx_pkt_cnt <= '0;
            rx_err_cnt <= '0;
        end else begin
            if (pop && m_eop) rx_pkt_cnt <= rx_pkt_cnt + CNT_W'(1);
            if (frm_err)      rx_err_cnt <= rx_err_cnt + CNT_W'(1);
        end
    end
`else
    // Statistics counters are not built in this configuration.
`endif

endmodule
